// File: rtl/clock_divider_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : clock_divider_if                                       |
// | Description : Divisor request and divided-clock outputs of the       |
// |               programmable clock divider.                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface clock_divider_if #(
  parameter int WIDTH = 20
);
  logic [WIDTH-1:0] div;      // requested period in clk cycles, 0 = stopped
  logic             clk_out;  // divided clock, ~50% duty
  logic             tick;     // one-cycle pulse on each clk_out rising edge

  // Consumer of the divided clock: supplies the period, observes outputs
  modport master (
    output div,
    input  clk_out,
    input  tick
  );

  // The divider itself
  modport slave (
    input  div,
    output clk_out,
    output tick
  );
endinterface
`default_nettype wire

// File: rtl/clock_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : clock_divider                                          |
// | Description : Programmable integer clock divider. Produces a         |
// |               registered slow clock (high ceil(N/2), low floor(N/2)) |
// |               and a one-cycle tick on each of its rising edges.      |
// |               The period is resampled only at period boundaries.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module clock_divider #(
  parameter int WIDTH = 20
) (
  input  logic           clk,
  input  logic           reset,
  clock_divider_if.slave bus
);

  localparam logic [WIDTH-1:0] C_ONE      = WIDTH'(1);
  localparam logic [WIDTH:0]   C_ONE_WIDE = (WIDTH+1)'(1);

  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  // High-phase length of the next period; one extra bit so that
  // div = 2^WIDTH-1 does not overflow when rounding up.
  logic [WIDTH:0]   w_high_len;
  logic             w_idle;
  logic             w_wrap;
  logic             w_div_nz;

  assign w_idle   = (div_q == '0);
  assign w_wrap   = (cnt_q == (div_q - C_ONE));
  assign w_div_nz = (bus.div != '0);

  // Next-state: reload while idle or at the wrap, otherwise advance.
  // The period-end compare uses the shadow div_q, never the live input.
  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (w_idle || w_wrap) begin
      div_d  = bus.div;
      cnt_d  = '0;
      tick_d = w_div_nz;
    end else begin
      cnt_d  = cnt_q + C_ONE;
    end
  end

  // clk_out is derived from next-state values so the registered output
  // is glitch-free and always satisfies the duty-cycle invariant.
  always_comb begin
    w_high_len = ({1'b0, div_d} + C_ONE_WIDE) >> 1;
    clk_out_d  = (div_d != '0) && ({1'b0, cnt_d} < w_high_len);
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.clk_out = clk_out_q;
  assign bus.tick    = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_clock_divider                                       |
// | Description : Directed self-checking bench for clock_divider.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_clock_divider;

  logic clk;
  logic reset;

  clock_divider_if #(.WIDTH(20)) u_bus ();
  clock_divider_if #(.WIDTH(4))  u_bus4 ();

  clock_divider #(.WIDTH(20)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_bus.slave)
  );

  // Narrow instance to exercise the all-ones divisor 2^WIDTH-1
  clock_divider #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (u_bus4.slave)
  );

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle 1 ns past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check one full period of length n with `high` high cycles; optionally
  // drive a new divisor right after the cycle at index chg_at.
  task automatic run_period(input string tag, input int n, input int high,
                            input int chg_at = -1, input int new_div = 0);
    for (int k = 0; k < n; k++) begin
      step();
      check_eq($sformatf("%s.clk[%0d]", tag, k), 32'(u_bus.clk_out), (k < high) ? 32'd1 : 32'd0);
      check_eq($sformatf("%s.tick[%0d]", tag, k), 32'(u_bus.tick), (k == 0) ? 32'd1 : 32'd0);
      if (k == chg_at) u_bus.div = 20'(new_div);
    end
  endtask

  initial begin
    reset      = 1'b1;
    u_bus.div  = '0;
    u_bus4.div = '0;
    #1;
    check_eq("rst.clk_async", 32'(u_bus.clk_out), 32'd0);
    check_eq("rst.tick_async", 32'(u_bus.tick), 32'd0);
    step();
    step();
    check_eq("rst.clk", 32'(u_bus.clk_out), 32'd0);
    check_eq("rst.tick", 32'(u_bus.tick), 32'd0);

    // div=4: 1,1,0,0 with tick at each period start
    reset     = 1'b0;
    u_bus.div = 20'd4;
    run_period("d4a", 4, 2);
    run_period("d4b", 4, 2);
    run_period("d4c", 4, 2);

    // div=5: high 3 / low 2, 100 periods without drift
    u_bus.div = 20'd5;
    for (int p = 0; p < 100; p++) run_period($sformatf("d5p%0d", p), 5, 3);

    // div=1: constant high with tick every cycle, then div=2
    u_bus.div = 20'd1;
    for (int p = 0; p < 4; p++) run_period($sformatf("d1p%0d", p), 1, 1);
    u_bus.div = 20'd2;
    for (int p = 0; p < 3; p++) run_period($sformatf("d2p%0d", p), 2, 1);

    // div 6 -> 3 changed at cnt=2: current period stays 6 long
    u_bus.div = 20'd6;
    run_period("d6chg", 6, 3, 2, 3);
    for (int p = 0; p < 3; p++) run_period($sformatf("d3p%0d", p), 3, 2);

    // div=0 mid-period: current period finishes, then idle
    run_period("d3stop", 3, 2, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq($sformatf("idle.clk[%0d]", k), 32'(u_bus.clk_out), 32'd0);
      check_eq($sformatf("idle.tick[%0d]", k), 32'(u_bus.tick), 32'd0);
    end
    u_bus.div = 20'd4;
    run_period("d4restart", 4, 2);

    // Sweep divisor 14920: high 7460, tick spacing 14920
    u_bus.div = 20'd14920;
    run_period("sw0", 14920, 7460);
    run_period("sw1", 14920, 7460);

    // Async reset mid-period, in a cycle where clk_out and tick are high
    step();
    check_eq("pre_rst.clk", 32'(u_bus.clk_out), 32'd1);
    check_eq("pre_rst.tick", 32'(u_bus.tick), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst.clk", 32'(u_bus.clk_out), 32'd0);
    check_eq("async_rst.tick", 32'(u_bus.tick), 32'd0);
    step();
    step();
    check_eq("held_rst.clk", 32'(u_bus.clk_out), 32'd0);
    reset = 1'b0;
    run_period("sw_restart", 14920, 7460);

    // All-ones divisor on the 4-bit instance: N=15, high 8, low 7
    u_bus4.div = 4'd15;
    for (int k = 0; k < 30; k++) begin
      step();
      check_eq($sformatf("w4.clk[%0d]", k), 32'(u_bus4.clk_out), ((k % 15) < 8) ? 32'd1 : 32'd0);
      check_eq($sformatf("w4.tick[%0d]", k), 32'(u_bus4.tick), ((k % 15) == 0) ? 32'd1 : 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clock_divider.md
Name: clock_divider

Overview:
- Programmable integer clock divider.
- Derives a slow, roughly 50%-duty enable clock from the system clock `clk`. The period in `clk` cycles is set by the `div` input.
- Used by the square-wave channel to generate its sweep clock, with period 14920*(1+pindex) cycles. Also provides a one-cycle `tick` marking each rising edge of the slow clock.

Parameters:
- WIDTH, 20, bit width of `div` and the internal counter. 20 bits covers the worst sweep divisor 119360.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- div  input  WIDTH  requested period in `clk` cycles. 0 means stopped.
- clk_out  output  1  divided clock, registered (glitch-free).
- tick  output  1  one-cycle pulse, registered; high in the cycle `clk_out` rises.

Behaviour:
- State registers:
  - `div_q` (WIDTH): shadow of the active period.
  - `cnt` (WIDTH): position within the period, 0..div_q-1.
  - `clk_out`.
  - `tick`.
- Reset, asynchronous and active-high: `div_q`=0, `cnt`=0, `clk_out`=0, `tick`=0 immediately, held while `reset`=1.
- Invariant, true every cycle: `clk_out` = (`div_q`≠0) AND (`cnt` < (`div_q`+1)>>1).
  - High for ceil(N/2) cycles, then low for floor(N/2) cycles.
  - Implemented as a register computed from the next-state values, never combinationally.
- Idle state (`div_q`=0), each clock edge:
  - `div_q` <= `div`, `cnt` <= 0, `tick` <= (`div`≠0), `clk_out` <= (`div`≠0).
  - A nonzero `div` therefore starts the first period on the next edge, with `clk_out` and `tick` high.
- Running state (`div_q`=N≠0), each clock edge:
  - If `cnt` = N-1 (period end, wrap): `cnt` <= 0, `div_q` <= `div` (resample), `tick` <= (`div`≠0).
  - Otherwise: `cnt` <= `cnt`+1, `tick` <= 0.
- Divisor changes:
  - Take effect only at a period boundary. Changes mid-period are ignored until the wrap.
  - No truncated or stretched periods.
- `div` = 0 sampled at a wrap: the block enters idle.
  - `clk_out`=0, `tick`=0 from the next cycle.
  - `cnt` holds 0.
  - Restarts as soon as `div` becomes nonzero.
- `div` = 1: `cnt` stays 0, `clk_out` stays 1, `tick` is high every cycle.
- `div` = 2: `clk_out` toggles 1,0,1,0; `tick` is high on each 1-cycle.
- Odd N: the extra cycle belongs to the high phase. Example N=5: high 3 cycles, low 2.
- Arithmetic:
  - Unsigned.
  - `cnt` never exceeds `div_q`-1, so no wrap-around hazard.
  - N = 2^WIDTH-1 is supported.
  - The compare N-1 uses `div_q`, never live `div`.
- Reset asserted mid-period: outputs drop to 0 asynchronously.
  - After release, the first edge follows the idle rule (reload from `div`).
- Latency: the first `clk_out` rising edge occurs 1 `clk` edge after `reset` deasserts with `div`≠0, or after `div` leaves 0 while idle.

Test Plan:
- Reset, then `div`=4: after the first edge `clk_out` = 1,1,0,0 repeating; `tick` high at `cnt`=0 each period (every 4th cycle); period exactly 4.
- `div`=5: `clk_out` high 3 / low 2 cycles; `tick` every 5 cycles; no drift over 100 periods.
- `div`=1 then `div`=2: `clk_out` constant 1 with `tick` every cycle; after the next wrap, toggles with period 2 and `tick` on alternate cycles.
- Change `div` 6→3 at `cnt`=2: the current period completes all 6 cycles (high 3, low 3); subsequent periods are 3 cycles (high 2, low 1).
- `div`=0 during running, then `div`=4: outputs go 0 after the current period ends; they restart with `clk_out`=1 and `tick`=1 one edge after `div`=4 is applied.
- Sweep value `div`=14920 (and 119360): `tick` spacing 14920 (resp. 119360) cycles; `clk_out` high 7460 (resp. 59680). Assert `reset` mid-period: `clk_out` and `tick` fall immediately without waiting for an edge; operation restarts one edge after release.
